// File: rtl/inst_mem_loader.sv
// Streams 32-bit instruction words into a byte-addressed instruction RAM, MSB first.
// Optional running checksum of accepted words is enabled with INST_LOADER_CHECKSUM_EN.
module inst_mem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           word_in,
  input  logic                  word_last,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH-2:0] word_count
`ifdef INST_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = {{(ADDR_WIDTH-3){1'b0}}, 3'd4};
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD  = ADDR_WIDTH'(DEPTH - 4);
  localparam logic [ADDR_WIDTH-2:0] COUNT_ONE  = {{(ADDR_WIDTH-2){1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic [31:0]           word, word_nxt;
  logic                  last, last_nxt;
  logic [1:0]            byte_idx, byte_idx_nxt;
  logic                  word_ready_nxt, mem_we_nxt, busy_nxt, done_nxt, overflow_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [7:0]            mem_data_nxt;
  logic [ADDR_WIDTH-2:0] word_count_nxt;
  logic [31:0]           sum, sum_nxt;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_sel = w[31:24];
      2'd1:    byte_sel = w[23:16];
      2'd2:    byte_sel = w[15:8];
      default: byte_sel = w[7:0];
    endcase
  endfunction

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    word_nxt       = word;
    last_nxt       = last;
    byte_idx_nxt   = byte_idx;
    word_ready_nxt = 1'b0;
    mem_we_nxt     = 1'b0;
    mem_addr_nxt   = mem_addr;
    mem_data_nxt   = mem_data;
    busy_nxt       = busy;
    done_nxt       = done;
    overflow_nxt   = overflow;
    word_count_nxt = word_count;
    sum_nxt        = sum;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          ptr_nxt        = base_addr & ALIGN_MASK;
          word_count_nxt = '0;
          done_nxt       = 1'b0;
          overflow_nxt   = 1'b0;
          busy_nxt       = 1'b1;
          sum_nxt        = 32'd0;
          word_ready_nxt = 1'b1;
          state_nxt      = ACCEPT;
        end else begin
          state_nxt = state;
        end
      end
      ACCEPT: begin
        word_ready_nxt = 1'b1;
        if (word_valid && word_ready) begin
          word_nxt       = word_in;
          last_nxt       = word_last;
          byte_idx_nxt   = 2'd0;
          sum_nxt        = sum + word_in;
          word_ready_nxt = 1'b0;
          mem_we_nxt     = 1'b1;
          mem_addr_nxt   = ptr;
          mem_data_nxt   = word_in[31:24];
          state_nxt      = WRITE;
        end else begin
          state_nxt = ACCEPT;
        end
      end
      WRITE: begin
        if (byte_idx != 2'd3) begin
          byte_idx_nxt = byte_idx + 2'd1;
          mem_we_nxt   = 1'b1;
          mem_addr_nxt = ptr + {{(ADDR_WIDTH-2){1'b0}}, byte_idx_nxt};
          mem_data_nxt = byte_sel(word, byte_idx_nxt);
        end else begin
          ptr_nxt        = ptr + WORD_STEP;
          word_count_nxt = word_count + COUNT_ONE;
          // last wins over end-of-RAM, so a final word in the top slot is not an overflow
          if (last) begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = DONE;
          end else if (ptr == LAST_WORD) begin
            done_nxt     = 1'b1;
            overflow_nxt = 1'b1;
            busy_nxt     = 1'b0;
            state_nxt    = DONE;
          end else begin
            word_ready_nxt = 1'b1;
            state_nxt      = ACCEPT;
          end
        end
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      word       <= 32'd0;
      last       <= 1'b0;
      byte_idx   <= 2'd0;
      word_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
      sum        <= 32'd0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      word       <= word_nxt;
      last       <= last_nxt;
      byte_idx   <= byte_idx_nxt;
      word_ready <= word_ready_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_data   <= mem_data_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      overflow   <= overflow_nxt;
      word_count <= word_count_nxt;
      sum        <= sum_nxt;
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  assign checksum = sum;
`else
  logic unused_sum;
  assign unused_sum = ^sum;
`endif

endmodule
